// File: rtl/traffic_light_ctrl.sv
// Four-phase intersection light controller (A green, A yellow, B green, B yellow).
// Parade mode (i_M) parks Street B on green; yellows always run to completion.
module traffic_light_ctrl #(
    parameter int YELLOW_CYCLES    = 5,
    parameter int MIN_GREEN_CYCLES = 10,
    parameter int CNT_W            = 8
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic       i_M,
    input  logic       i_TA,
    input  logic       i_TB,
    output logic [1:0] o_LA,
    output logic [1:0] o_LB,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        S_AG = 2'd0,
        S_AY = 2'd1,
        S_BG = 2'd2,
        S_BY = 2'd3
    } state_t;

    localparam logic [1:0] L_GREEN  = 2'b00;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b10;

    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(MIN_GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic   w_green_done;
    logic   w_yel_done;
    logic   w_leave;
    state_t w_next;

    // The counter saturates, so a long-held green stays eligible to leave.
    assign w_green_done = (r_cnt >= GREEN_LAST);
    assign w_yel_done   = (r_cnt == YEL_LAST);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_leave = 1'b0;
        w_next  = r_state;
        case (r_state)
            S_AG: if (w_green_done && (i_M || !i_TA)) begin
                w_leave = 1'b1;
                w_next  = S_AY;
            end
            S_AY: if (w_yel_done) begin
                w_leave = 1'b1;
                w_next  = S_BG;
            end
            S_BG: if (w_green_done && !i_M && !i_TB) begin
                w_leave = 1'b1;
                w_next  = S_BY;
            end
            S_BY: if (w_yel_done) begin
                w_leave = 1'b1;
                w_next  = S_AG;
            end
            default: begin
                w_leave = 1'b1;
                w_next  = S_AG;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_AG;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_leave) begin
                r_cnt <= '0;
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Moore decode from the state register only.
    always_comb begin
        o_LA = L_RED;
        o_LB = L_RED;
        case (r_state)
            S_AG: begin o_LA = L_GREEN;  o_LB = L_RED;    end
            S_AY: begin o_LA = L_YELLOW; o_LB = L_RED;    end
            S_BG: begin o_LA = L_RED;    o_LB = L_GREEN;  end
            S_BY: begin o_LA = L_RED;    o_LB = L_YELLOW; end
            default: begin o_LA = L_GREEN; o_LB = L_RED;  end
        endcase
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: directed scenarios plus random inputs,
// two instances (8-bit and 3-bit dwell counter) compared against a phase/elapsed-time model.
module tb_traffic_light_ctrl;

    localparam int Y  = 3;
    localparam int MG = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    logic m    = 1'b0;
    logic ta   = 1'b0;
    logic tb   = 1'b0;

    logic [1:0] a_la, a_lb, a_st;
    logic [1:0] b_la, b_lb, b_st;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase index 0..3 and elapsed cycles in that phase (unbounded int).
    int ph = 0;
    int el = 0;
    logic [1:0] la_tab [4] = '{2'b00, 2'b01, 2'b10, 2'b10};
    logic [1:0] lb_tab [4] = '{2'b10, 2'b10, 2'b00, 2'b01};

    always #5 clk = ~clk;

    traffic_light_ctrl #(.YELLOW_CYCLES(Y), .MIN_GREEN_CYCLES(MG), .CNT_W(8)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_M(m), .i_TA(ta), .i_TB(tb),
        .o_LA(a_la), .o_LB(a_lb), .o_state(a_st)
    );

    traffic_light_ctrl #(.YELLOW_CYCLES(Y), .MIN_GREEN_CYCLES(MG), .CNT_W(3)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_M(m), .i_TA(ta), .i_TB(tb),
        .o_LA(b_la), .o_LB(b_lb), .o_state(b_st)
    );

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " A.state"}, a_st, 2'(ph));
        chk({tag, " A.LA"},    a_la, la_tab[ph]);
        chk({tag, " A.LB"},    a_lb, lb_tab[ph]);
        chk({tag, " B.state"}, b_st, 2'(ph));
        chk({tag, " B.LA"},    b_la, la_tab[ph]);
        chk({tag, " B.LB"},    b_lb, lb_tab[ph]);
    endtask

    // Advance the model by the rules of the sequence, using inputs present before the edge.
    task automatic model_step();
        bit go;
        if (!rstn) begin
            ph = 0;
            el = 0;
            return;
        end
        case (ph)
            0:       go = (el >= MG - 1) && (m || !ta);
            2:       go = (el >= MG - 1) && !m && !tb;
            default: go = (el == Y - 1);
        endcase
        if (go) begin
            ph = (ph + 1) % 4;
            el = 0;
        end else begin
            el++;
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Called just after a rising edge: asynchronous assert, hold across one edge, release.
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        ph = 0;
        el = 0;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        rstn = 1'b1;
    endtask

    initial begin
        int exp_ph;

        #2;
        rstn = 1'b0;
        #1;
        check_all("rst_initial");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Scenario 1: traffic on A keeps A green indefinitely.
        ta = 1'b1;
        for (int i = 0; i < 30; i++) tick("s1_hold");
        chk("s1_state_after_30", a_st, 2'd0);

        // Scenario 2: free-running period of 14 cycles.
        do_reset();
        ta = 1'b0; tb = 1'b0; m = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            tick("s2_free");
            exp_ph = (k % 14) < 4 ? 0 : (k % 14) < 7 ? 1 : (k % 14) < 11 ? 2 : 3;
            chk("s2_period", a_st, 2'(exp_ph));
            checks++;
            assert (a_la !== 2'b11 && a_lb !== 2'b11) else begin
                failures++;
                $error("FAIL s2_no_11: got LA=%b LB=%b expected neither 11", a_la, a_lb);
            end
        end

        // Scenario 3: parade raised in AG at cnt=1 with traffic on A.
        do_reset();
        ta = 1'b1;
        tick("s3_ag");
        m = 1'b1;
        for (int i = 0; i < 3; i++) tick("s3_ag");
        chk("s3_ay_at_edge4", a_st, 2'd1);
        for (int i = 0; i < 3; i++) tick("s3_ay");
        chk("s3_bg_entered", a_st, 2'd2);
        tb = 1'b0;
        for (int i = 0; i < 50; i++) tick("s3_parked");
        chk("s3_bg_parked_50", a_st, 2'd2);
        m = 1'b0;
        tick("s3_leave");
        chk("s3_by_next_edge", a_st, 2'd3);

        // Scenario 4: parade raised at BY cnt=0; yellow completes, AG lasts exactly 4.
        m = 1'b1;
        ta = 1'b1;
        for (int i = 0; i < 3; i++) tick("s4_by");
        chk("s4_ag_after_by", a_st, 2'd0);
        for (int i = 0; i < 3; i++) tick("s4_ag");
        chk("s4_ag_still", a_st, 2'd0);
        tick("s4_ag_exit");
        chk("s4_ay_after_4", a_st, 2'd1);
        for (int i = 0; i < 13; i++) tick("s4_park");
        chk("s4_bg_parked", a_st, 2'd2);

        // Scenario 5: asynchronous reset in the middle of AY.
        m = 1'b0; ta = 1'b0; tb = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) tick("s5_run");
        chk("s5_in_ay", a_st, 2'd1);
        #2;
        rstn = 1'b0;
        #1;
        ph = 0;
        el = 0;
        chk("s5_async_LA", a_la, 2'b00);
        chk("s5_async_LB", a_lb, 2'b10);
        check_all("s5_async");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick("s5_ag");
        chk("s5_ag_restart", a_st, 2'd0);
        tick("s5_ag_exit");
        chk("s5_ay_after_4", a_st, 2'd1);

        // Scenario 6: long AG saturates the 3-bit counter without wrapping.
        do_reset();
        ta = 1'b1;
        for (int i = 0; i < 20; i++) tick("s6_hold");
        chk("s6_B_ag_held", b_st, 2'd0);
        ta = 1'b0;
        tick("s6_exit");
        chk("s6_B_ay_next_edge", b_st, 2'd1);

        // Random phase: biased inputs, parade toggling occasionally.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            ta = ($urandom_range(0, 3) != 0);
            tb = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) m = ~m;
            tick("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
# traffic_light_ctrl

Intersection light controller and the consumer of the parade-mode signal `M` from the mode FSM. It runs a four-state Moore sequence: Street A green, A yellow, Street B green, B yellow. Traffic sensors `i_TA`/`i_TB` and a minimum-green timer control the sequence. While parade mode is active (`i_M=1`), the controller parks Street B on green. Both share `i_clk` and `i_rstn`.

## Interface
- `YELLOW_CYCLES`, default 5: yellow duration in clock cycles; must be ≥1 and ≤2^CNT_W−1.
- `MIN_GREEN_CYCLES`, default 10: minimum green duration in cycles; must be ≥1 and ≤2^CNT_W−1.
- `CNT_W`, default 8: width of the dwell counter.
- `i_clk`, in, 1: clock; all state updates on the rising edge.
- `i_rstn`, in, 1: reset, asynchronous, active-low.
- `i_M`, in, 1: parade mode from the mode FSM; synchronous to `i_clk`.
- `i_TA`, in, 1: traffic present on Street A; synchronous.
- `i_TB`, in, 1: traffic present on Street B; synchronous.
- `o_LA`, out, 2: Street A light; 2'b00 green, 2'b01 yellow, 2'b10 red. 2'b11 is never driven.
- `o_LB`, out, 2: Street B light; same encoding.
- `o_state`, out, 2: current state (S_AG=0, S_AY=1, S_BG=2, S_BY=3).

## Operation
- **State register and dwell counter.**
  - State is a 2-bit register.
  - The dwell counter `cnt` (CNT_W bits) is 0 in the first cycle of every state.
  - It increments each cycle the state is held and saturates at all-ones; it never wraps.
  - Any transition clears it to 0.
- **Green eligibility:** `green_done = (cnt >= MIN_GREEN_CYCLES-1)`.
- **Yellow completion:** `yel_done = (cnt == YELLOW_CYCLES-1)`.
- **S_AG** (LA=green, LB=red):
  - Goes to S_AY when `green_done && (i_M || !i_TA)`.
  - Otherwise holds.
- **S_AY** (LA=yellow, LB=red): goes to S_BG when `yel_done`. `i_M`, `i_TA` and `i_TB` are ignored.
- **S_BG** (LA=red, LB=green):
  - Goes to S_BY when `green_done && !i_M && !i_TB`.
  - While `i_M=1` it holds indefinitely, regardless of `i_TB`.
- **S_BY** (LA=red, LB=yellow): goes to S_AG when `yel_done`. Inputs are ignored.
- **Yellow is never aborted.**
  - If `i_M` rises during S_BY, the yellow completes and the controller enters S_AG.
  - It then leaves S_AG as soon as `green_done`, even with `i_TA=1`.
- **`i_M` during S_AY:** the sequence continues into S_BG and parks there.
- **Output decode:** outputs are decoded combinationally from the state register only (Moore). Inputs never reach the outputs in the same cycle.
- **Reset values:**
  - State S_AG and `cnt=0`.
  - `o_LA=2'b00`, `o_LB=2'b10`, `o_state=2'b00`.
- **Illegal states:** none are reachable with a 2-bit encoding. The default branch returns to S_AG.

## Timing
- **Transition latency:** the transition condition is evaluated combinationally from the current state, `cnt` and inputs. The state changes on the next rising edge, and the outputs change in that same edge's cycle.
- **Yellow length:** each yellow lasts exactly YELLOW_CYCLES cycles.
- **Green length:** each green lasts at least MIN_GREEN_CYCLES cycles. With its leave condition already true on entry, it lasts exactly MIN_GREEN_CYCLES.
- **Free-running period:** with `i_TA=i_TB=i_M=0`, the period is 2·(MIN_GREEN_CYCLES+YELLOW_CYCLES) cycles.
- **Leaving parade mode:** when `i_M` falls during S_BG with `green_done` true and `i_TB=0`, the state moves to S_BY at the next edge.
- **Reset assertion:** asserting `i_rstn` low in any cycle forces the reset values immediately, without waiting for a clock edge.
- **Reset release:** the first edge after release evaluates S_AG with `cnt=0`.
- **Saturation:** at saturation the counter holds all-ones, so `green_done` stays true.

## Test plan
All scenarios use YELLOW_CYCLES=3 and MIN_GREEN_CYCLES=4 unless noted.

1. **Reset hold:** reset, then hold `i_TA=1`, `i_TB=0`, `i_M=0` for 30 cycles → outputs stay LA=00, LB=10, state=0 throughout.
2. **Free-running sequence:** after reset, drive `i_TA=i_TB=i_M=0` → repeating pattern of 4 cycles AG, 3 AY, 4 BG, 3 BY; period 14, no 2'b11 on either light.
3. **Parade:**
   - Set `i_M=1` in AG at cnt=1 with `i_TA=1` → AY at edge 4 after entry, held 3 cycles, then BG.
   - BG holds for 50 cycles with `i_TB=0`.
   - Drop `i_M` → BY on the next edge.
4. **Parade during yellow:** raise `i_M=1` at BY cnt=0 → BY completes all 3 cycles, AG lasts exactly 4 cycles despite `i_TA=1`, then AY and BG parked.
5. **Reset mid-operation:** assert `i_rstn` low at AY cnt=1, between clock edges → LA=00 and LB=10 asynchronously. After release, AG dwell restarts from 0 and lasts ≥4 cycles.
6. **Saturation:** with CNT_W=3, hold `i_TA=1` in AG for 20 cycles (counter saturates at 7), then drop `i_TA` → AY at the next edge, with no wrap-induced delay.
